// File: rtl/core_io_axil.sv
`default_nettype none
// ============================================================================
// core_io_axil : AXI4-Lite master that polls a status register, then moves
//                one word from the RX register or to the TX register.
// Revision     : 1.0
// ============================================================================
module core_io_axil #(
  parameter int                  ADDR_W   = 4,
  parameter int                  DATA_W   = 32,
  parameter logic [ADDR_W-1:0]   RX_OFS   = 'h0,
  parameter logic [ADDR_W-1:0]   TX_OFS   = 'h4,
  parameter logic [ADDR_W-1:0]   STAT_OFS = 'h8,
  parameter int                  RXV_BIT  = 0,
  parameter int                  TXF_BIT  = 3,
  parameter logic [DATA_W/8-1:0] TX_STRB  = 'b0001,
  parameter int                  POLL_MAX = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'((POLL_MAX > 0) ? POLL_MAX - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POLL_AR = 3'd1,
    POLL_R  = 3'd2,
    DATA_AR = 3'd3,
    DATA_R  = 3'd4,
    WR_AWW  = 3'd5,
    WR_B    = 3'd6,
    RESP    = 3'd7
  } state_t;

  state_t              state, state_nxt;
  logic [PCW-1:0]      poll_cnt, poll_cnt_nxt;
  logic                is_write, is_write_nxt;
  logic [DATA_W-1:0]   wr_data, wr_data_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt;
  logic [1:0]          rsp_err_nxt;
  logic [ADDR_W-1:0]   araddr_nxt, awaddr_nxt;
  logic                arvalid_nxt, awvalid_nxt, wvalid_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [DATA_W/8-1:0] wstrb_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      poll_cnt  <= '0;
      is_write  <= 1'b0;
      wr_data   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
      busy      <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      state     <= state_nxt;
      poll_cnt  <= poll_cnt_nxt;
      is_write  <= is_write_nxt;
      wr_data   <= wr_data_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      busy      <= (state_nxt != IDLE);
      araddr    <= araddr_nxt;
      arvalid   <= arvalid_nxt;
      rready    <= (state_nxt == POLL_R) || (state_nxt == DATA_R);
      awaddr    <= awaddr_nxt;
      awvalid   <= awvalid_nxt;
      wdata     <= wdata_nxt;
      wstrb     <= wstrb_nxt;
      wvalid    <= wvalid_nxt;
      bready    <= (state_nxt == WR_B);
    end
  end

  always_comb begin
    state_nxt     = state;
    poll_cnt_nxt  = poll_cnt;
    is_write_nxt  = is_write;
    wr_data_nxt   = wr_data;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          is_write_nxt = req_write;
          wr_data_nxt  = req_wdata;
          poll_cnt_nxt = '0;
          state_nxt    = POLL_AR;
        end
      end
      POLL_AR: if (arvalid && arready) state_nxt = POLL_R;
      POLL_R: begin
        if (rvalid && rready) begin
          if (rresp != 2'b00) begin
            rsp_err_nxt = 2'b01;
            state_nxt   = RESP;
          end else if (!is_write && rdata[RXV_BIT]) begin
            state_nxt = DATA_AR;
          end else if (is_write && !rdata[TXF_BIT]) begin
            state_nxt = WR_AWW;
          end else if ((POLL_MAX != 0) && (poll_cnt == POLL_LAST)) begin
            rsp_err_nxt = 2'b10;
            state_nxt   = RESP;
          end else begin
            // Saturate so an unbounded poll (POLL_MAX == 0) never wraps.
            if (poll_cnt != {PCW{1'b1}}) poll_cnt_nxt = poll_cnt + 1'b1;
            state_nxt = POLL_AR;
          end
        end
      end
      DATA_AR: if (arvalid && arready) state_nxt = DATA_R;
      DATA_R: begin
        if (rvalid && rready) begin
          if (rresp == 2'b00) begin
            rsp_rdata_nxt = rdata;
            rsp_err_nxt   = 2'b00;
          end else begin
            rsp_err_nxt   = 2'b01;
          end
          state_nxt = RESP;
        end
      end
      WR_AWW: begin
        // Each channel counts as done once its VALID has dropped or handshakes now.
        if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = WR_B;
      end
      WR_B: begin
        if (bvalid && bready) begin
          rsp_err_nxt = (bresp != 2'b00) ? 2'b01 : 2'b00;
          state_nxt   = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    araddr_nxt  = araddr;
    arvalid_nxt = arvalid;
    awaddr_nxt  = awaddr;
    awvalid_nxt = awvalid;
    wdata_nxt   = wdata;
    wstrb_nxt   = wstrb;
    wvalid_nxt  = wvalid;

    if (arvalid && arready) arvalid_nxt = 1'b0;
    if (awvalid && awready) awvalid_nxt = 1'b0;
    if (wvalid && wready)   wvalid_nxt  = 1'b0;

    if (state_nxt != state) begin
      case (state_nxt)
        POLL_AR: begin
          araddr_nxt  = STAT_OFS;
          arvalid_nxt = 1'b1;
        end
        DATA_AR: begin
          araddr_nxt  = RX_OFS;
          arvalid_nxt = 1'b1;
        end
        WR_AWW: begin
          awaddr_nxt  = TX_OFS;
          wdata_nxt   = wr_data;
          wstrb_nxt   = TX_STRB;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/core_io_axil.md
CORE_IO_AXIL -- requirements
Module: core_io_axil

Interface
REQ-001 Parameter ADDR_W, default 4: AXI4-Lite address width.
REQ-002 Parameter DATA_W, default 32: AXI data width; SHALL be 32 or 64.
REQ-003 Parameter RX_OFS, default 'h0: RX data register offset.
REQ-004 Parameter TX_OFS, default 'h4: TX data register offset.
REQ-005 Parameter STAT_OFS, default 'h8: status register offset.
REQ-006 Parameter RXV_BIT, default 0: status bit meaning "RX data valid".
REQ-007 Parameter TXF_BIT, default 3: status bit meaning "TX FIFO full".
REQ-008 Parameter TX_STRB, default 'b0001: WSTRB value for TX writes, DATA_W/8 bits wide.
REQ-009 Parameter POLL_MAX, default 1023: status polls before timeout; 0 means poll forever.
REQ-010 CLK in 1: sole clock, rising edge.
REQ-011 RST_N in 1: asynchronous, active-low reset.
REQ-012 REQ_VALID in 1: the core requests an IN or OUT transfer.
REQ-013 REQ_READY out 1: request accepted when REQ_VALID and REQ_READY are both high.
REQ-014 REQ_WRITE in 1: 1 means OUT (TX write), 0 means IN (RX read).
REQ-015 REQ_WDATA in DATA_W: OUT data, sampled at acceptance.
REQ-016 RSP_VALID out 1: one-cycle completion pulse.
REQ-017 RSP_RDATA out DATA_W: IN data; holds until the next IN completes.
REQ-018 RSP_ERR out 2: 00 OK, 01 slave error (xRESP not OKAY), 10 poll timeout; valid with RSP_VALID.
REQ-019 BUSY out 1: high whenever the FSM is not in IDLE.
REQ-020 AXI4-Lite master ports, widths per ADDR_W/DATA_W: ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY, AWADDR, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY.

Function
REQ-021 The FSM SHALL use states IDLE, POLL_AR, POLL_R, DATA_AR, DATA_R, WR_AWW, WR_B, RESP.
REQ-022 REQ_READY SHALL be high only in IDLE; acceptance stores REQ_WRITE and REQ_WDATA, clears poll_cnt, and moves to POLL_AR.
REQ-023 POLL_AR: ARADDR=STAT_OFS, ARVALID high; on ARVALID&ARREADY, ARVALID drops next cycle and the FSM moves to POLL_R.
REQ-024 POLL_R: RREADY high; on RVALID&RREADY the next state SHALL be selected in this priority order:
  - RRESP!=00: RESP with ERR=01.
  - Read request and RDATA[RXV_BIT]=1: DATA_AR.
  - Write request and RDATA[TXF_BIT]=0: WR_AWW.
  - POLL_MAX!=0 and poll_cnt==POLL_MAX-1: RESP with ERR=10.
  - Otherwise: poll_cnt+1, back to POLL_AR.
REQ-025 poll_cnt SHALL be wide enough for POLL_MAX-1 and SHALL never wrap.
REQ-026 DATA_AR: ARADDR=RX_OFS, same handshake as POLL_AR, then DATA_R.
REQ-027 DATA_R: RREADY high; on handshake, RSP_RDATA<=RDATA and ERR<=(RRESP!=00 ? 01 : 00), then RESP.
REQ-028 WR_AWW: on entry, AWADDR=TX_OFS, WDATA=stored data, WSTRB=TX_STRB, and AWVALID and WVALID rise together.
REQ-029 In WR_AWW, each VALID SHALL drop independently after its own handshake; both handshakes may occur in the same cycle or in either order.
REQ-030 The FSM SHALL leave WR_AWW for WR_B only once both handshakes are complete.
REQ-031 WR_B: BREADY high; on BVALID&BREADY, ERR<=(BRESP!=00 ? 01 : 00), then RESP.
REQ-032 RESP: RSP_VALID high for exactly one cycle, then IDLE; RSP_RDATA is unchanged on writes and on errors.
REQ-033 An asserted VALID SHALL stay high with stable address and data until its handshake.
REQ-034 No output SHALL depend combinationally on any AXI input; all outputs are registered.
REQ-035 Latency with zero-wait slaves (AR/AW/WREADY high, R/BVALID returned the cycle after request), first poll passing: RSP_VALID 5 cycles after acceptance for both IN and OUT.
REQ-036 Each extra failed poll SHALL add 2 cycles.
REQ-037 REQ_VALID while BUSY SHALL be ignored; the request stays pending until IDLE.

Reset
REQ-038 On RST_N low, asynchronously:
  - FSM to IDLE, poll_cnt=0.
  - All VALID/READY outputs 0, RSP_VALID 0, RSP_ERR 00, RSP_RDATA 0.
  - ARADDR, AWADDR, WDATA 0; WSTRB 0; BUSY 0.
REQ-039 Reset mid-transfer SHALL abandon the transaction with no RSP_VALID; REQ_READY rises on the first clock edge after release.

Verification
REQ-040 IN, status=0x1 first poll, RX RDATA=0x5A, zero-wait slave -> ARADDR 0x8 then 0x0; RSP_VALID 5 cycles after accept; RSP_RDATA=0x5A; ERR=00.
REQ-041 OUT 0x41, status 0x8 twice then 0x0 -> three status reads; AWADDR=0x4, WDATA=0x41, WSTRB=0001; RSP_VALID 9 cycles after accept.
REQ-042 OUT with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles; exactly one B handshake; ERR=00.
REQ-043 IN, status always 0x0, POLL_MAX=4 -> exactly 4 status reads, no RX read; RSP_ERR=10; RSP_RDATA unchanged.
REQ-044 OUT, BRESP=10 -> RSP_ERR=01; IN with poll RRESP=11 -> RSP_ERR=01, no RX read.
REQ-045 RST_N low during WR_B -> BREADY, AWVALID, WVALID 0 immediately; no RSP_VALID; after release a new IN completes normally.
